// File: rtl/dmem_ctrl.sv
// Two-port round-robin arbiter and access sequencer in front of the data memory.
// Sub-word stores become a word read-modify-write; bad requests get an error response without touching memory.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_we,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    input  logic [2:0]  p0_req_mask,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_we,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    input  logic [2:0]  p1_req_mask,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,

    output logic [31:0] dm_addr,
    output logic [31:0] dm_wr_data,
    output logic        dm_mem_wr,
    output logic        dm_mem_rd,
    output logic [2:0]  dm_mask,
    input  logic [31:0] dm_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned MW = 3;
    localparam int unsigned IW = 30;

    localparam logic [MW-1:0] M_B  = 3'b000;
    localparam logic [MW-1:0] M_H  = 3'b001;
    localparam logic [MW-1:0] M_W  = 3'b010;
    localparam logic [MW-1:0] M_BU = 3'b100;
    localparam logic [MW-1:0] M_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        RMW_WR,
        WSTORE,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            port_q, port_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [DW-1:0]   word_q, word_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            any_valid;
    logic            grant_port;
    logic            sel_we;
    logic [DW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [MW-1:0]   sel_mask;
    logic            sel_bad;

    function automatic logic req_error(input logic [DW-1:0] a, input logic we, input logic [MW-1:0] m);
        logic bad;
        bad = (a[31:2] >= IW'(DEPTH_WORDS));
        case (m)
            M_B, M_BU: ;
            M_H, M_HU: bad = bad | a[0];
            M_W:       bad = bad | (a[1:0] != 2'b00);
            default:   bad = 1'b1;
        endcase
        bad = bad | (we & m[2]);
        return bad;
    endfunction

    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] a, input logic [MW-1:0] m);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (m)
            M_B:     r = {{24{b[7]}}, b};
            M_BU:    r = {24'h000000, b};
            M_H:     r = {{16{h[15]}}, h};
            M_HU:    r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] w, input logic [DW-1:0] d,
                                                 input logic [1:0] a, input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = w;
        if (m[1:0] == 2'b00) begin
            r[{a, 3'b000} +: 8] = d[7:0];
        end else begin
            r[{a[1], 4'b0000} +: 16] = d[15:0];
        end
        return r;
    endfunction

    // On a tie the port not served last time wins.
    assign any_valid  = p0_req_valid | p1_req_valid;
    assign grant_port = (p0_req_valid & p1_req_valid) ? ~last_q : p1_req_valid;
    assign sel_we     = grant_port ? p1_req_we    : p0_req_we;
    assign sel_addr   = grant_port ? p1_req_addr  : p0_req_addr;
    assign sel_wdata  = grant_port ? p1_req_wdata : p0_req_wdata;
    assign sel_mask   = grant_port ? p1_req_mask  : p0_req_mask;
    assign sel_bad    = req_error(sel_addr, sel_we, sel_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        p0_rsp_valid = 1'b0;
        p0_rsp_rdata = '0;
        p0_rsp_err   = 1'b0;
        p1_rsp_valid = 1'b0;
        p1_rsp_rdata = '0;
        p1_rsp_err   = 1'b0;
        dm_addr      = '0;
        dm_wr_data   = '0;
        dm_mem_wr    = 1'b0;
        dm_mem_rd    = 1'b0;
        dm_mask      = '0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    p0_req_ready = ~grant_port;
                    p1_req_ready = grant_port;
                    last_d  = grant_port;
                    port_d  = grant_port;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    mask_d  = sel_mask;
                    rdata_d = '0;
                    err_d   = sel_bad;
                    if (sel_bad) begin
                        state_d = RESP;
                    end else if (!sel_we) begin
                        state_d = LOAD;
                    end else if (sel_mask == M_W) begin
                        state_d = WSTORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                dm_mem_rd = 1'b1;
                dm_mask   = mask_q;
                dm_addr   = addr_q;
                rdata_d   = load_ext(dm_rdata, addr_q[1:0], mask_q);
                state_d   = RESP;
            end
            RMW_RD: begin
                dm_mem_rd = 1'b1;
                dm_mask   = M_W;
                dm_addr   = {addr_q[31:2], 2'b00};
                word_d    = dm_rdata;
                state_d   = RMW_WR;
            end
            RMW_WR: begin
                dm_mem_wr  = 1'b1;
                dm_mask    = M_W;
                dm_addr    = {addr_q[31:2], 2'b00};
                dm_wr_data = lane_merge(word_q, wdata_q, addr_q[1:0], mask_q);
                state_d    = RESP;
            end
            WSTORE: begin
                dm_mem_wr  = 1'b1;
                dm_mask    = M_W;
                dm_addr    = addr_q;
                dm_wr_data = wdata_q;
                state_d    = RESP;
            end
            RESP: begin
                if (port_q) begin
                    p1_rsp_valid = 1'b1;
                    p1_rsp_rdata = rdata_q;
                    p1_rsp_err   = err_q;
                end else begin
                    p0_rsp_valid = 1'b1;
                    p0_rsp_rdata = rdata_q;
                    p0_rsp_err   = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle never handshakes, responds or touches memory.
        if (!rst_n) begin
            p0_req_ready = 1'b0;
            p1_req_ready = 1'b0;
            p0_rsp_valid = 1'b0;
            p0_rsp_rdata = '0;
            p0_rsp_err   = 1'b0;
            p1_rsp_valid = 1'b0;
            p1_rsp_rdata = '0;
            p1_rsp_err   = 1'b0;
            dm_addr      = '0;
            dm_wr_data   = '0;
            dm_mem_wr    = 1'b0;
            dm_mem_rd    = 1'b0;
            dm_mask      = '0;
        end
    end

endmodule
